// File: rtl/lenet_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lenet_bram_pkg
// Purpose  : Shared constants and types for the LeNet-5 BRAM stream reader.
//            BRAM word size, default widths and the reader FSM state type.
// Revision : 1.0  initial release
// ============================================================================
package lenet_bram_pkg;

  localparam int BRAM_WORD_BYTES = 4;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // Reader FSM, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage : lenet_bram_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with a first-word-fall-through head and an
//            occupancy count. DEPTH must be a power of two, >= 2.
// Ports    : clk, rst (async, active-high)
//            i_wr_en / i_wr_data  : push
//            i_rd_en              : pop (ignored when empty)
//            o_rd_data            : current head, 0 while empty
//            o_empty, o_count     : status
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo
  import lenet_bram_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_rd_en && !o_empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push  = i_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to 0 when empty so stale storage never reaches the stream.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_reader
// Purpose  : Reads a run of 32-bit words from a byte-addressed BRAM (1-cycle
//            registered read) and presents them as a valid/ready stream.
//            A read is issued only when the in-flight word plus the buffered
//            words leave room in the output FIFO, so stalls never lose data.
// Ports    : clk, rst (async, active-high)
//            i_start, i_base_addr, i_num_words : transfer request
//            o_busy, o_done                    : status
//            o_bram_en/wen/addr/din, i_bram_dout : BRAM read port
//            o_m_data, o_m_valid, i_m_ready, o_m_last : output stream
// Options  : BRAM_READER_2D_EN adds i_row_words / i_row_pitch for strided
//            row-by-row windows; row_words == 0 behaves linearly.
// Revision : 1.0  initial release
// ============================================================================
module bram_stream_reader
  import lenet_bram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_num_words,
`ifdef BRAM_READER_2D_EN
  input  logic [LEN_W-1:0]  i_row_words,
  input  logic [ADDR_W-1:0] i_row_pitch,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_bram_en,
  output logic [3:0]        o_bram_wen,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_din,
  input  logic [DATA_W-1:0] i_bram_dout,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_popped;
  logic              r_outstanding;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_pop;
  logic              w_last_word;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_base_aligned;

  assign w_base_aligned = i_base_addr & ~ADDR_W'(BRAM_WORD_BYTES - 1);

  // Credit: the read in flight (at most one) will land next cycle, so it
  // counts against FIFO space together with what is already buffered.
  assign w_credit_ok = ({1'b0, w_count} + SUM_W'(r_outstanding)) < SUM_W'(FIFO_DEPTH);
  assign w_issue     = (r_state == RUN) && w_credit_ok;
  assign w_pop       = !w_empty && i_m_ready;
  assign w_last_word = (r_popped == (r_len - LEN_W'(1)));

`ifdef BRAM_READER_2D_EN
  logic [LEN_W-1:0]  r_row_words;
  logic [LEN_W-1:0]  r_row_cnt;
  logic [ADDR_W-1:0] r_row_pitch;
  logic [ADDR_W-1:0] r_row_start;
  logic              w_row_end;

  assign w_row_end   = (r_row_words != '0) && (r_row_cnt == (r_row_words - LEN_W'(1)));
  assign w_next_addr = w_row_end ? (r_row_start + r_row_pitch)
                                 : (r_addr + ADDR_W'(BRAM_WORD_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_words <= '0;
      r_row_cnt   <= '0;
      r_row_pitch <= '0;
      r_row_start <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_row_words <= i_row_words;
      r_row_cnt   <= '0;
      r_row_pitch <= i_row_pitch;
      r_row_start <= w_base_aligned;
    end else if (w_issue) begin
      if (w_row_end) begin
        r_row_cnt   <= '0;
        r_row_start <= w_next_addr;
      end else begin
        r_row_cnt   <= r_row_cnt + LEN_W'(1);
      end
    end
  end
`else
  assign w_next_addr = r_addr + ADDR_W'(BRAM_WORD_BYTES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_popped      <= '0;
      r_outstanding <= 1'b0;
    end else begin
      // Every issued read is captured exactly one cycle later.
      r_outstanding <= w_issue;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr   <= w_base_aligned;
            r_len    <= i_num_words;
            r_issued <= '0;
            r_popped <= '0;
            r_state  <= (i_num_words != '0) ? RUN : FIN;
          end
        end
        RUN: begin
          if (w_issue) begin
            r_addr   <= w_next_addr;
            r_issued <= r_issued + LEN_W'(1);
            if (r_issued == (r_len - LEN_W'(1))) begin
              r_state <= DRAIN;
            end
          end
          if (w_pop) begin
            r_popped <= r_popped + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (w_pop) begin
            r_popped <= r_popped + LEN_W'(1);
            if (w_last_word) begin
              r_state <= FIN;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_outstanding),
    .i_wr_data (i_bram_dout),
    .i_rd_en   (w_pop),
    .o_rd_data (o_m_data),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign o_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign o_done      = (r_state == FIN);
  assign o_bram_en   = w_issue;
  assign o_bram_wen  = 4'b0000;
  assign o_bram_addr = r_addr;
  assign o_bram_din  = '0;
  assign o_m_valid   = !w_empty;
  assign o_m_last    = !w_empty && w_last_word;

endmodule : bram_stream_reader
`default_nettype wire

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- DMA-style read engine that fetches a contiguous run of 32-bit words from a byte-addressed BRAM and presents them as a valid/ready stream to the LeNet-5 compute stages (conv/pool/fc input).
- Sits directly downstream of the feature/weight BRAM and drives its read port.
- Hides the 1-cycle registered read latency with a small credit-controlled FIFO, so backpressure never drops or duplicates data.

Parameters:
- ADDR_W, 32, BRAM byte-address width.
- DATA_W, 32, word width.
- LEN_W, 16, width of the word-count field.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte start address; must be word aligned (bits [1:0] ignored).
- num_words  in  LEN_W  number of words to read.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transfer completes.
- bram_en  out  1  BRAM enable (read strobe).
- bram_wen  out  4  tied 4'b0000.
- bram_addr  out  ADDR_W  byte address; word index is bram_addr>>2.
- bram_din  out  DATA_W  tied 0.
- bram_dout  in  DATA_W  BRAM read data, valid the cycle after bram_en.
- m_data  out  DATA_W  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final word of a transfer.

Behaviour:
- Reset (asynchronous, active-high) values: every output 0; FSM in IDLE; FIFO empty; all counters 0.
- Reset mid-transfer: the transfer is abandoned and no done pulse is produced.
- FSM states:
  - IDLE -> RUN on start with num_words != 0. base_addr and num_words are latched; busy=1 next cycle.
  - IDLE -> FIN on start with num_words == 0. No reads are issued.
  - RUN -> DRAIN when the last read is issued (issued count == num_words).
  - DRAIN -> FIN on the handshake of the m_last word.
  - FIN -> IDLE unconditionally. done=1 and busy=0 during FIN.
- start while not in IDLE: ignored.
- Read issue:
  - bram_en=1 in RUN when outstanding + fifo_count < FIFO_DEPTH.
  - bram_addr = latched_base + 4*issued. It advances by 4 per issued read.
- Capture: a read issued in cycle t is written into the FIFO at the end of cycle t+1, since BRAM dout is registered.
  - outstanding is 0 or 1. The credit rule guarantees the FIFO never overflows.
- Stream handshake:
  - A word transfers when m_valid && m_ready.
  - m_valid = FIFO not empty.
  - m_data and m_last are stable while m_valid && !m_ready.
- m_last: asserted for word index num_words-1, tracked by a popped-word counter.
- Latency: start in cycle 0 -> bram_en in cycle 1 -> first m_valid in cycle 3.
- Throughput: with m_ready held high, 1 word/cycle sustained (FIFO_DEPTH >= 2).
- Simultaneous FIFO push and pop in one cycle: count unchanged; both the write and the read take effect.
- Address wrap: bram_addr wraps modulo 2^ADDR_W. No error flag is raised.
- num_words = 2^LEN_W-1: supported; counters are LEN_W bits wide.

Optional Feature:
- Macro name: BRAM_READER_2D_EN.
- Defined:
  - Adds inputs row_words (LEN_W) and row_pitch (ADDR_W, bytes); both are latched at start.
  - After every row_words issued reads, the address jumps to row_start + row_pitch. This is used for strided windows of a 28x28 / 14x14 feature map.
  - num_words remains the total count.
  - row_words == 0 is treated as linear mode.
- Undefined: the ports are absent and addressing is purely linear.

Decomposition:
- Package lenet_bram_pkg:
  - BRAM_WORD_BYTES=4.
  - Default widths.
  - State enum {IDLE, RUN, DRAIN, FIN}.
- Sub-module sync_fifo: parameterised DEPTH/WIDTH, synchronous, count output, first-word-fall-through head.
- FSM, address generator and credit logic stay in bram_stream_reader.

Test Plan:
- Basic read: mem[0..7]=0x100+i; base_addr=0, num_words=8, m_ready=1.
  - Expect m_data 0x100..0x107 in order, consecutive cycles, first m_valid 3 cycles after start.
  - Expect m_last on 0x107, then done one cycle after the last handshake.
- Backpressure: base_addr=0x40, num_words=16, m_ready random 30% high.
  - Expect all 16 words in order, no duplicates, and m_data stable while stalled.
  - bram_en must never fire when outstanding + fifo_count == 4.
- Zero length: num_words=0.
  - Expect bram_en never asserted, done pulses in cycle 1 or 2, and m_valid stays 0.
- Start while busy: a second start mid-transfer with a different base_addr.
  - Expect it ignored and the original 8 words delivered.
- Async reset mid-transfer: assert rst during word 3 of 8.
  - Expect all outputs 0 immediately, no done pulse, and a clean new transfer afterwards.
- 2D mode (BRAM_READER_2D_EN): base 0, row_words=5, row_pitch=112, num_words=10.
  - Expect word addresses 0..16 (bytes) then 112..128.
